// File: rtl/mod2011_chunk_reducer_if.sv
// mod2011_chunk_reducer_if: chunk input stream and residue output handshake
interface mod2011_chunk_reducer_if #(
  parameter int CHUNK_W = 6,
  parameter int RES_W   = 11
);
  logic               in_valid;
  logic               in_ready;
  logic [CHUNK_W-1:0] in_chunk;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [RES_W-1:0]   out_residue;
  logic               out_trunc;
  modport master (output in_valid, in_chunk, in_last, out_ready,
                  input  in_ready, out_valid, out_residue, out_trunc);
  modport slave  (input  in_valid, in_chunk, in_last, out_ready,
                  output in_ready, out_valid, out_residue, out_trunc);
endinterface

// File: rtl/mod2011_chunk_reducer.sv
// mod2011_chunk_reducer: MSB-first chunk stream to residue mod MOD via Horner update
module mod2011_chunk_reducer #(
  parameter int MOD        = 2011,
  parameter int CHUNK_W    = 6,
  parameter int NUM_CHUNKS = 84,
  parameter int RES_W      = 11
) (
  input logic clk,
  input logic rst_n,
  mod2011_chunk_reducer_if.slave s
);
  localparam int T_W = RES_W + CHUNK_W;
  localparam int CNT_W = $clog2(NUM_CHUNKS + 1);
  localparam logic [T_W-1:0] MODT = T_W'(MOD);
  localparam logic [T_W-1:0] FOLD = T_W'((1 << RES_W) % MOD);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nxt;
  logic [RES_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic trunc, xfer, term;
  logic [T_W-1:0] t, u, v, w;
  // acc < MOD, so concatenation equals acc*2^CHUNK_W + chunk; fold top bits by 2^RES_W mod MOD
  always_comb begin
    t = {acc, s.in_chunk};
    u = {{RES_W{1'b0}}, t[T_W-1:RES_W]} * FOLD + {{CHUNK_W{1'b0}}, t[RES_W-1:0]};
    v = u >= MODT ? u - MODT : u;
    w = v >= MODT ? v - MODT : v;
  end
  assign xfer = s.in_valid & s.in_ready;
  assign term = xfer & (s.in_last | cnt == CNT_W'(NUM_CHUNKS - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = term ? DONE : xfer ? ACCUM : IDLE;
      ACCUM:   state_nxt = term ? DONE : ACCUM;
      DONE:    state_nxt = s.out_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    s.in_ready    = rst_n & (state != DONE);
    s.out_valid   = state == DONE;
    s.out_residue = acc;
    s.out_trunc   = trunc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      trunc <= 1'b0;
    end else if (state == DONE) begin
      if (s.out_ready) begin
        acc   <= '0;
        cnt   <= '0;
        trunc <= 1'b0;
      end
    end else if (xfer) begin
      acc   <= w[RES_W-1:0];
      cnt   <= cnt + 1'b1;
      trunc <= term & ~s.in_last;
    end
endmodule

// File: tb/tb_mod2011_chunk_reducer.sv
// tb_mod2011_chunk_reducer: directed and randomized checks of the mod-2011 chunk reducer
module tb_mod2011_chunk_reducer;
  logic clk = 0;
  logic rst_n = 0;
  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  mod2011_chunk_reducer_if ifc ();
  mod2011_chunk_reducer dut (.clk(clk), .rst_n(rst_n), .s(ifc));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input logic [5:0] c, input logic l);
    int n = 0;
    @(negedge clk);
    ifc.in_valid = 1; ifc.in_chunk = c; ifc.in_last = l;
    while (!ifc.in_ready && n < 300) begin @(negedge clk); n++; end
    if (!ifc.in_ready) begin
      vectors++; errors++;
      $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    @(posedge clk);
  endtask

  task automatic finish_op(input string name, input int exp_res, input logic exp_trunc, input int delay);
    @(negedge clk);
    ifc.in_valid = 0; ifc.in_last = 0; ifc.in_chunk = 6'($urandom);
    vectors += 3;
    if (ifc.out_valid !== 1'b1) begin errors++; $display("FAIL %s_latency: out_valid=%b want 1", name, ifc.out_valid); end
    if (ifc.out_residue !== 11'(exp_res)) begin errors++; $display("FAIL %s_residue: got %0d want %0d", name, ifc.out_residue, exp_res); end
    if (ifc.out_trunc !== exp_trunc) begin errors++; $display("FAIL %s_trunc: got %b want %b", name, ifc.out_trunc, exp_trunc); end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      vectors++;
      if (ifc.out_residue !== 11'(exp_res) || ifc.in_ready !== 1'b0) begin
        errors++; $display("FAIL %s_hold: residue=%0d in_ready=%b want %0d/0", name, ifc.out_residue, ifc.in_ready, exp_res);
      end
    end
    ifc.out_ready = 1;
    @(negedge clk);
    ifc.out_ready = 0;
    vectors++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_release: out_valid=%b in_ready=%b want 0/1", name, ifc.out_valid, ifc.in_ready);
    end
  endtask

  task automatic test_reset();
    ifc.in_valid = 0; ifc.in_chunk = 0; ifc.in_last = 0; ifc.out_ready = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    vectors += 2;
    if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hs: in_ready=%b out_valid=%b want 0/0", ifc.in_ready, ifc.out_valid);
    end
    if (ifc.out_residue !== 11'd0 || ifc.out_trunc !== 1'b0) begin
      errors++; $display("FAIL reset_data: residue=%0d trunc=%b want 0/0", ifc.out_residue, ifc.out_trunc);
    end
    rst_n = 1;
    @(negedge clk);
    vectors++;
    if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release: in_ready=%b want 1", ifc.in_ready); end
  endtask

  task automatic test_single();
    push(63, 1); finish_op("single63", 63, 0, 0);
  endtask

  task automatic test_modulus();
    push(31, 0); push(27, 1); finish_op("val2011", 0, 0, 0);
    push(63, 0); push(63, 1); finish_op("val4095", 73, 0, 0);
    push(1, 0); push(0, 0); push(0, 1); finish_op("val4096", 74, 0, 0);
  endtask

  task automatic test_backpressure();
    push(63, 0); push(63, 1);
    @(negedge clk);
    ifc.in_valid = 1; ifc.in_chunk = 5; ifc.in_last = 1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b1 || ifc.out_residue !== 11'd73) begin
        errors++; $display("FAIL bp_stall%0d: in_ready=%b out_valid=%b residue=%0d want 0/1/73", i, ifc.in_ready, ifc.out_valid, ifc.out_residue);
      end
      @(negedge clk);
    end
    ifc.out_ready = 1;
    @(negedge clk);
    ifc.out_ready = 0; ifc.in_valid = 0;
    vectors++;
    if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0", ifc.in_ready, ifc.out_valid);
    end
    push(5, 1); finish_op("bp_next", 5, 0, 0);
  endtask

  task automatic test_trunc();
    int m = 0;
    int t0;
    for (int i = 0; i < 84; i++) m = (m * 64 + 63) % 2011;
    t0 = cyc;
    for (int i = 0; i < 84; i++) push(63, 0);
    vectors++;
    if (cyc - t0 !== 84) begin errors++; $display("FAIL throughput: %0d cycles for 84 chunks want 84", cyc - t0); end
    @(negedge clk);
    ifc.in_valid = 1; ifc.in_chunk = 63; ifc.in_last = 1;
    vectors += 2;
    if (ifc.out_valid !== 1'b1 || ifc.out_trunc !== 1'b1 || ifc.in_ready !== 1'b0) begin
      errors++; $display("FAIL trunc_flags: out_valid=%b trunc=%b in_ready=%b want 1/1/0", ifc.out_valid, ifc.out_trunc, ifc.in_ready);
    end
    if (ifc.out_residue !== 11'(m)) begin errors++; $display("FAIL trunc_residue: got %0d want %0d", ifc.out_residue, m); end
    repeat (2) @(negedge clk);
    ifc.out_ready = 1;
    @(negedge clk);
    ifc.out_ready = 0;
    @(negedge clk);
    ifc.in_valid = 0; ifc.in_last = 0;
    vectors++;
    if (ifc.out_valid !== 1'b1 || ifc.out_residue !== 11'd63 || ifc.out_trunc !== 1'b0) begin
      errors++; $display("FAIL trunc_85th: out_valid=%b residue=%0d trunc=%b want 1/63/0", ifc.out_valid, ifc.out_residue, ifc.out_trunc);
    end
    ifc.out_ready = 1;
    @(negedge clk);
    ifc.out_ready = 0;
  endtask

  task automatic test_reset_mid();
    push(10, 0); push(20, 0); push(30, 0);
    @(negedge clk);
    ifc.in_valid = 0;
    rst_n = 0;
    #1;
    vectors++;
    if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b0 || ifc.out_residue !== 11'd0) begin
      errors++; $display("FAIL midreset: in_ready=%b out_valid=%b residue=%0d want 0/0/0", ifc.in_ready, ifc.out_valid, ifc.out_residue);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    vectors++;
    if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL midreset_release: in_ready=%b want 1", ifc.in_ready); end
    push(63, 0); push(63, 1); finish_op("after_reset", 73, 0, 0);
  endtask

  task automatic test_random();
    for (int op = 0; op < 150; op++) begin
      int len = $urandom_range(1, 84);
      logic nolast = (len == 84) && ($urandom_range(1) == 1);
      int m = 0;
      for (int i = 0; i < len; i++) begin
        logic [5:0] c = 6'($urandom);
        if ($urandom_range(3) == 0) begin
          @(negedge clk);
          ifc.in_valid = 0; ifc.in_chunk = 6'($urandom);
          @(posedge clk);
        end
        m = (m * 64 + int'(c)) % 2011;
        push(c, (i == len - 1) && !nolast);
      end
      vectors++;
      if (ifc.out_residue >= 11'd2011) begin errors++; $display("FAIL rand_range: residue=%0d", ifc.out_residue); end
      finish_op($sformatf("rand%0d", op), m, nolast, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_modulus();
    test_backpressure();
    test_trunc();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
